// File: rtl/vp_pkg.sv
// Shared types and helpers for the video-pipeline sync controller.
// State encoding and the width function used to size the pixel position counters.
package vp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LINE   = 2'd2,
    ST_HBLANK = 2'd3
  } state_t;

  localparam int SYNC_W = 3;

  // Bits needed to index 0..value-1; never returns less than 1 so ports stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vp_sync_ctrl_if.sv
// Sync/enable bundle of the RGB->YCbCr pixel pipeline timing controller.
// The master drives raw video timing; the slave returns the aligned, qualified timing.
interface vp_sync_ctrl_if
  import vp_pkg::*;
#(
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 64
) ();

  localparam int XW = clog2(H_ACTIVE);
  localparam int YW = clog2(V_ACTIVE);

  logic          in_de;
  logic          in_hsync;
  logic          in_vsync;
  logic          out_de;
  logic          out_hsync;
  logic          out_vsync;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          line_err;
  logic          frame_err;

  modport master (
    output in_de, in_hsync, in_vsync,
    input  out_de, out_hsync, out_vsync, out_x, out_y,
    input  sof, eol, eof, line_err, frame_err
  );

  modport slave (
    input  in_de, in_hsync, in_vsync,
    output out_de, out_hsync, out_vsync, out_x, out_y,
    output sof, eol, eof, line_err, frame_err
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for the sync/enable bundle.
// All stages clear on reset so no stale timing survives into the next frame.
module sync_delay_line #(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  logic [N-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/vp_sync_ctrl.sv
// Timing controller for the fixed-latency RGB->YCbCr pipeline: delays sync/enable,
// tracks pixel position, gates partial frames and flags malformed lines/frames.
module vp_sync_ctrl
  import vp_pkg::*;
#(
  parameter int LATENCY  = 5,
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 64
) (
  input logic           clk,
  input logic           rst,
  vp_sync_ctrl_if.slave bus
);

  localparam int XW = clog2(H_ACTIVE);
  localparam int YW = clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [SYNC_W-1:0] d_bus;
  logic              d_vs;
  logic              d_hs;
  logic              d_de;
  logic              vs_prev_reg;
  logic              vs_rise;

  state_t            state_reg;
  state_t            state_next;
  logic [XW-1:0]     x_reg;
  logic [XW-1:0]     x_next;
  logic [YW-1:0]     y_reg;
  logic [YW-1:0]     y_next;
  logic              full_reg;
  logic              full_next;
  logic              lerr_done_reg;
  logic              lerr_done_next;

  logic              emit;
  logic [XW-1:0]     emit_x;
  logic [YW-1:0]     emit_y;
  logic              sof_next;
  logic              eol_next;
  logic              eof_next;
  logic              lerr_next;
  logic              ferr_next;

  logic              de_reg;
  logic              hs_reg;
  logic              vs_reg;
  logic [XW-1:0]     x_out_reg;
  logic [YW-1:0]     y_out_reg;
  logic              sof_reg;
  logic              eol_reg;
  logic              eof_reg;
  logic              lerr_reg;
  logic              ferr_reg;

  // The delay line supplies LATENCY-1 stages; the output registers below are the last one.
  sync_delay_line #(
    .N     (SYNC_W),
    .DEPTH (LATENCY - 1)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({bus.in_vsync, bus.in_hsync, bus.in_de}),
    .dout (d_bus)
  );

  assign d_vs    = d_bus[2];
  assign d_hs    = d_bus[1];
  assign d_de    = d_bus[0];
  assign vs_rise = d_vs & ~vs_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      full_reg      <= 1'b0;
      lerr_done_reg <= 1'b0;
      vs_prev_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      full_reg      <= full_next;
      lerr_done_reg <= lerr_done_next;
      vs_prev_reg   <= d_vs;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    full_next      = full_reg;
    lerr_done_next = lerr_done_reg;
    emit           = 1'b0;
    emit_x         = x_reg;
    emit_y         = y_reg;
    sof_next       = 1'b0;
    lerr_next      = 1'b0;
    ferr_next      = 1'b0;

    if (vs_rise) begin
      // Lines completed since sof: y in mid-line, y+1 once the line has closed.
      ferr_next      = (state_reg == ST_LINE) ||
                       ((state_reg == ST_HBLANK) && (y_reg != Y_LAST));
      x_next         = '0;
      y_next         = '0;
      full_next      = 1'b0;
      lerr_done_next = 1'b0;
      if (d_de) begin
        emit       = 1'b1;
        emit_x     = '0;
        emit_y     = '0;
        sof_next   = 1'b1;
        state_next = ST_LINE;
      end else begin
        state_next = ST_SYNC;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
        end
        ST_SYNC: begin
          if (d_de) begin
            emit       = 1'b1;
            emit_x     = '0;
            emit_y     = '0;
            sof_next   = 1'b1;
            state_next = ST_LINE;
          end
        end
        ST_LINE: begin
          if (d_de) begin
            if (!full_reg) begin
              emit = 1'b1;
            end else if (!lerr_done_reg) begin
              lerr_next      = 1'b1;
              lerr_done_next = 1'b1;
            end
          end else begin
            lerr_next  = ~full_reg;
            state_next = ST_HBLANK;
          end
        end
        ST_HBLANK: begin
          if (d_de) begin
            if (y_reg != Y_LAST) begin
              emit           = 1'b1;
              emit_x         = '0;
              emit_y         = y_reg + 1'b1;
              y_next         = y_reg + 1'b1;
              lerr_done_next = 1'b0;
              state_next     = ST_LINE;
            end else begin
              ferr_next  = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // x saturates on the last column; further pixels on the line are dropped.
    if (emit) begin
      if (emit_x == X_LAST) begin
        x_next    = emit_x;
        full_next = 1'b1;
      end else begin
        x_next    = emit_x + 1'b1;
        full_next = 1'b0;
      end
    end
  end

  assign eol_next = emit && (emit_x == X_LAST);
  assign eof_next = eol_next && (emit_y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      de_reg    <= 1'b0;
      hs_reg    <= 1'b0;
      vs_reg    <= 1'b0;
      x_out_reg <= '0;
      y_out_reg <= '0;
      sof_reg   <= 1'b0;
      eol_reg   <= 1'b0;
      eof_reg   <= 1'b0;
      lerr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      de_reg    <= emit;
      hs_reg    <= d_hs;
      vs_reg    <= d_vs;
      if (emit) begin
        x_out_reg <= emit_x;
        y_out_reg <= emit_y;
      end
      sof_reg   <= sof_next;
      eol_reg   <= eol_next;
      eof_reg   <= eof_next;
      lerr_reg  <= lerr_next;
      ferr_reg  <= ferr_next;
    end
  end

  assign bus.out_de    = de_reg;
  assign bus.out_hsync = hs_reg;
  assign bus.out_vsync = vs_reg;
  assign bus.out_x     = x_out_reg;
  assign bus.out_y     = y_out_reg;
  assign bus.sof       = sof_reg;
  assign bus.eol       = eol_reg;
  assign bus.eof       = eof_reg;
  assign bus.line_err  = lerr_reg;
  assign bus.frame_err = ferr_reg;

endmodule

// File: tb/tb_vp_sync_ctrl.sv
// Directed bench for vp_sync_ctrl (LATENCY=5, 4x2 frame): table of per-cycle inputs with
// expected outputs, plus hand-written reset and post-reset gating sequences.
module tb_vp_sync_ctrl;

  localparam int LAT = 5;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int OFS = LAT - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vp_sync_ctrl_if #(.H_ACTIVE(H), .V_ACTIVE(V)) bus ();

  vp_sync_ctrl #(
    .LATENCY  (LAT),
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       vs;
    logic       hs;
    logic       de;
    logic       e_de;
    logic [1:0] e_x;
    logic       e_y;
    logic       e_sof;
    logic       e_eol;
    logic       e_eof;
    logic       e_lerr;
    logic       e_ferr;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [1:0] hold_x;
  logic       hold_y;

  // {de, hsync, vsync, sof, eol, eof, line_err, frame_err, x[1:0], y}
  function automatic logic [10:0] actual_out();
    return {bus.out_de, bus.out_hsync, bus.out_vsync, bus.sof, bus.eol, bus.eof,
            bus.line_err, bus.frame_err, bus.out_x, bus.out_y};
  endfunction

  task automatic check(input string name, input logic [10:0] req);
    logic [10:0] act;
    act = actual_out();
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
      $display("%s ok de/hs/vs/sof/eol/eof/le/fe/x/y=%b", name, act);
    end else begin
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic drive(input logic vs, input logic hs, input logic de);
    bus.in_vsync = vs;
    bus.in_hsync = hs;
    bus.in_de    = de;
  endtask

  function automatic void blank(input logic vs, input logic hs, input logic de,
                                input logic lerr, input logic ferr);
    vec_t v;
    v.vs = vs; v.hs = hs; v.de = de;
    v.e_de = 1'b0; v.e_x = 2'd0; v.e_y = 1'b0;
    v.e_sof = 1'b0; v.e_eol = 1'b0; v.e_eof = 1'b0;
    v.e_lerr = lerr; v.e_ferr = ferr;
    tbl.push_back(v);
  endfunction

  function automatic void pix(input logic vs, input logic [1:0] x, input logic y,
                              input logic sof, input logic ferr);
    vec_t v;
    v.vs = vs; v.hs = 1'b0; v.de = 1'b1;
    v.e_de = 1'b1; v.e_x = x; v.e_y = y;
    v.e_sof = sof;
    v.e_eol = (x == 2'd3);
    v.e_eof = (x == 2'd3) && y;
    v.e_lerr = 1'b0; v.e_ferr = ferr;
    tbl.push_back(v);
  endfunction

  // Record i's expectation appears on the outputs OFS edges after record i is sampled.
  task automatic run_table(input int start, input int n);
    hold_x = 2'd0;
    hold_y = 1'b0;
    for (int i = 0; i < n + OFS; i++) begin
      if (i < n) drive(tbl[start+i].vs, tbl[start+i].hs, tbl[start+i].de);
      else       drive(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      if (i >= OFS) begin
        vec_t v;
        v = tbl[start+i-OFS];
        if (v.e_de) begin
          hold_x = v.e_x;
          hold_y = v.e_y;
        end
        check($sformatf("vec%0d", start + i - OFS),
              {v.e_de, v.hs, v.vs, v.e_sof, v.e_eol, v.e_eof, v.e_lerr, v.e_ferr,
               hold_x, hold_y});
      end
    end
  endtask

  initial begin
    // Clean frame: vsync, two 4-pixel lines
    blank(1, 0, 0, 0, 0); blank(1, 0, 0, 0, 0); blank(0, 1, 0, 0, 0); blank(0, 0, 0, 0, 0);
    pix(0, 0, 0, 1, 0); pix(0, 1, 0, 0, 0); pix(0, 2, 0, 0, 0); pix(0, 3, 0, 0, 0);
    blank(0, 1, 0, 0, 0); blank(0, 0, 0, 0, 0);
    pix(0, 0, 1, 0, 0); pix(0, 1, 1, 0, 0); pix(0, 2, 1, 0, 0); pix(0, 3, 1, 0, 0);
    blank(0, 1, 0, 0, 0); blank(0, 0, 0, 0, 0);
    // Short line then long line, then a third line that overflows the frame
    blank(1, 0, 0, 0, 0); blank(0, 0, 0, 0, 0);
    pix(0, 0, 0, 1, 0); pix(0, 1, 0, 0, 0); pix(0, 2, 0, 0, 0);
    blank(0, 0, 0, 1, 0); blank(0, 1, 0, 0, 0);
    pix(0, 0, 1, 0, 0); pix(0, 1, 1, 0, 0); pix(0, 2, 1, 0, 0); pix(0, 3, 1, 0, 0);
    blank(0, 0, 1, 1, 0); blank(0, 0, 1, 0, 0); blank(0, 1, 0, 0, 0); blank(0, 0, 0, 0, 0);
    blank(0, 0, 1, 0, 1); blank(0, 0, 1, 0, 0); blank(0, 1, 0, 0, 0);
    // New frame, vsync after one line
    blank(1, 0, 0, 0, 0); blank(0, 0, 0, 0, 0);
    pix(0, 0, 0, 1, 0); pix(0, 1, 0, 0, 0); pix(0, 2, 0, 0, 0); pix(0, 3, 0, 0, 0);
    blank(0, 1, 0, 0, 0); blank(1, 0, 0, 0, 1); blank(0, 0, 0, 0, 0);
    pix(0, 0, 0, 1, 0); pix(0, 1, 0, 0, 0); pix(0, 2, 0, 0, 0); pix(0, 3, 0, 0, 0);
    blank(0, 1, 0, 0, 0);
    // Vsync coincident with de in HBLANK: after 1 line (error), then after 2 lines (clean)
    pix(1, 0, 0, 1, 1); pix(0, 1, 0, 0, 0); pix(0, 2, 0, 0, 0); pix(0, 3, 0, 0, 0);
    blank(0, 1, 0, 0, 0);
    pix(0, 0, 1, 0, 0); pix(0, 1, 1, 0, 0); pix(0, 2, 1, 0, 0); pix(0, 3, 1, 0, 0);
    blank(0, 1, 0, 0, 0);
    pix(1, 0, 0, 1, 0); blank(0, 0, 0, 1, 0); blank(0, 0, 0, 0, 0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset%0d", i), 11'b0);
    end
    rst = 1'b0;

    run_table(0, tbl.size());

    // Reset during an active line, release mid-line: gate until the next vsync
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_mid%0d", i), 11'b0);
    end
    rst = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      drive(c == 8, c == 2, (c <= 3) || (c == 5) || (c == 6) || (c == 14));
      @(posedge clk);
      #1;
      check($sformatf("gate%0d", c),
            {c == 18, c == 6, c == 12, c == 18, 1'b0, 1'b0, c == 19, 1'b0, 2'd0, 1'b0});
    end

    // Reset while a frame is being output, then a clean frame
    for (int c = 0; c <= 8; c++) begin
      rst = (c == 8);
      drive(c == 0, 1'b0, (c >= 2) && (c < 8));
      @(posedge clk);
      #1;
      if (c == 6) check("midframe_sof", {1'b1, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0});
      if (c == 7) check("midframe_px1", {1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 2'd1, 1'b0});
      if (c == 8) check("midframe_rst", 11'b0);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    run_table(0, 16);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
